// File: rtl/sync_memory.sv
// sync_memory: single-port synchronous data memory with valid/ready requests, byte enables,
// a one-cycle registered response and a hardware init sequencer. Rev 1.0
`default_nettype none

module sync_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int INIT_WORDS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_done
);

  localparam int BE_W = DATA_WIDTH / 8;
  // One extra bit so DEPTH and INIT_WORDS compare cleanly even when DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   INIT_X  = (ADDR_WIDTH + 1)'(INIT_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   cur_word;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   init_val;

  assign req_ready = (state == ST_IDLE);
  assign init_done = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_X);

  always_comb begin
    cur_word = '0;
    if (in_range) begin
      cur_word = mem[req_addr];
    end
  end

  always_comb begin
    merged = cur_word;
    for (int k = 0; k < BE_W; k++) begin
      if (req_be[k]) begin
        merged[8*k +: 8] = req_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    init_val = '0;
    if ({1'b0, cnt} < INIT_X) begin
      init_val = DATA_WIDTH'(cnt);
    end
  end

  // The array itself is never reset; the INIT sweep rewrites every word.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= init_val;
    end else if (accept && req_we && in_range) begin
      mem[req_addr] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err   <= !in_range;
        rsp_rdata <= !in_range ? '0 : (req_we ? merged : cur_word);
      end
      case (state)
        ST_INIT: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          // A request in the same cycle is still served; its write is later overwritten.
          if (clear) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_memory.sv
// tb_sync_memory: directed vector bench for sync_memory (default build plus a DEPTH=48 build). Rev 1.0
`default_nettype none

module tb_sync_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        clear48 = 1'b0;
  logic        valid = 1'b0;
  logic        valid48 = 1'b0;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  logic        req_ready, rsp_valid, rsp_err, init_done;
  logic [31:0] rsp_rdata;
  logic        req_ready48, rsp_valid48, rsp_err48, init_done48;
  logic [31:0] rsp_rdata48;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_memory dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  sync_memory #(.DATA_WIDTH(32), .DEPTH(48), .INIT_WORDS(16)) dut48 (
    .clk(clk), .rst(rst), .clear(clear48),
    .req_valid(valid48), .req_ready(req_ready48), .req_we(req_we),
    .req_addr(req_addr[5:0]), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid48), .rsp_rdata(rsp_rdata48), .rsp_err(rsp_err48),
    .init_done(init_done48)
  );

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_req(input bit sel, input bit we, input logic [8:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_d, input bit exp_e,
                        input string nm);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    valid = !sel; valid48 = sel;
    @(posedge clk); #1;
    if (sel) begin
      check({nm, " valid"}, {31'd0, rsp_valid48}, 32'd1);
      check({nm, " rdata"}, rsp_rdata48, exp_d);
      check({nm, " err"}, {31'd0, rsp_err48}, {31'd0, exp_e});
    end else begin
      check({nm, " valid"}, {31'd0, rsp_valid}, 32'd1);
      check({nm, " rdata"}, rsp_rdata, exp_d);
      check({nm, " err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    valid = 1'b0; valid48 = 1'b0; clear = 1'b0;
  endtask

  // Counts rising edges until init_done is seen; any response during INIT is an error.
  task automatic wait_init(input string nm);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) seen = 1'b1;
      if (init_done) break;
    end
    valid = 1'b0;
    check({nm, " cycles"}, n, 32'd512);
    check({nm, " no rsp"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{0, 9'd0,   32'h0,        4'h0, 32'h0000_0000};
    vecs[1]  = '{0, 9'd5,   32'h0,        4'h0, 32'h0000_0005};
    vecs[2]  = '{0, 9'd63,  32'h0,        4'h0, 32'h0000_003F};
    vecs[3]  = '{0, 9'd64,  32'h0,        4'h0, 32'h0000_0000};
    vecs[4]  = '{1, 9'd10,  32'hAABBCCDD, 4'h5, 32'h00BB_00DD};
    vecs[5]  = '{0, 9'd10,  32'h0,        4'h0, 32'h00BB_00DD};
    vecs[6]  = '{1, 9'd3,   32'h12345678, 4'hF, 32'h1234_5678};
    vecs[7]  = '{0, 9'd3,   32'h0,        4'h0, 32'h1234_5678};
    vecs[8]  = '{1, 9'd511, 32'hFFFFFFFF, 4'h0, 32'h0000_0000};
    vecs[9]  = '{1, 9'd1,   32'hEE000000, 4'h8, 32'hEE00_0001};
    vecs[10] = '{0, 9'd1,   32'h0,        4'h0, 32'hEE00_0001};

    #12;
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset init_done", {31'd0, init_done}, 32'd0);
    check("reset req_ready", {31'd0, req_ready}, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    valid = 1'b1; req_addr = 9'd0;
    wait_init("init after reset");
    check("dut48 init_done", {31'd0, init_done48}, 32'd1);

    // Consecutive table entries run back-to-back (includes write-then-read of addr 3).
    for (int i = 0; i < 11; i++) begin
      do_req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp, 1'b0,
             $sformatf("vec%0d", i));
    end
    go_idle();
    @(posedge clk); #1;
    check("idle rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("idle rdata hold", rsp_rdata, 32'hEE00_0001);

    do_req(1'b1, 1'b0, 9'd47, 32'h0,        4'h0, 32'h0, 1'b0, "d48 rd47");
    do_req(1'b1, 1'b1, 9'd50, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "d48 wr50");
    do_req(1'b1, 1'b0, 9'd50, 32'h0,        4'h0, 32'h0, 1'b1, "d48 rd50");
    do_req(1'b1, 1'b0, 9'd47, 32'h0,        4'h0, 32'h0, 1'b0, "d48 rd47 again");
    do_req(1'b1, 1'b0, 9'd2,  32'h0,        4'h0, 32'h2, 1'b0, "d48 rd2");
    do_req(1'b1, 1'b0, 9'd50, 32'h0,        4'h0, 32'h0, 1'b1, "d48 rd50 again");
    go_idle();
    @(posedge clk); #1;
    check("d48 idle valid", {31'd0, rsp_valid48}, 32'd0);
    check("d48 idle err hold", {31'd0, rsp_err48}, 32'd1);

    // clear with a simultaneous write: response issued, then the init sweep overwrites it.
    @(negedge clk);
    clear = 1'b1; valid = 1'b1; req_we = 1'b1; req_addr = 9'd20;
    req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    @(posedge clk); #1;
    clear = 1'b0; valid = 1'b0;
    check("clear wr valid", {31'd0, rsp_valid}, 32'd1);
    check("clear wr rdata", rsp_rdata, 32'hFFFF_FFFF);
    check("clear ready drop", {31'd0, req_ready}, 32'd0);
    wait_init("init after clear");
    do_req(1'b0, 1'b0, 9'd20, 32'h0, 4'h0, 32'd20, 1'b0, "rd20 after clear");
    do_req(1'b0, 1'b0, 9'd3,  32'h0, 4'h0, 32'd3,  1'b0, "rd3 after clear");
    go_idle();

    // Reset mid-INIT: restart via clear, then pull rst low around count 100.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    check("pre-rst rdata hold", rsp_rdata, 32'd3);
    rst = 1'b0;
    #1;
    check("async rst rdata", rsp_rdata, 32'd0);
    check("async rst valid", {31'd0, rsp_valid}, 32'd0);
    check("async rst done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_init("init after mid rst");
    do_req(1'b0, 1'b0, 9'd63, 32'h0, 4'h0, 32'd63, 1'b0, "rd63 after rst");
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
